// File: rtl/add_seq_pkg.sv
// Shared types and constants for the byte-serial multi-byte adder.
package add_seq_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder_8bit.sv
// 8-bit ripple-carry adder; overflow is the unsigned carry-out of bit 7.
module adder_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       carry_in,
    output logic [7:0] sum,
    output logic       overflow
);

    // Ripple the carry from bit 0 upward.
    always_comb begin
        logic c;
        sum = '0;
        c   = carry_in;
        for (int unsigned i = 0; i < 8; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        overflow = c;
    end

endmodule

// File: rtl/multibyte_add_seq.sv
// Byte-serial unsigned adder: feeds adder_8bit one limb per cycle, LSB first,
// chaining the carry and collecting sum bytes, with valid/ready on both sides.
module multibyte_add_seq #(
    parameter int unsigned NUM_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*NUM_BYTES-1:0] in_a,
    input  logic [8*NUM_BYTES-1:0] in_b,
    input  logic                   in_carry,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*NUM_BYTES-1:0] out_sum,
    output logic                   out_carry,
    output logic                   busy
);
    import add_seq_pkg::*;

    localparam int unsigned IDX_W = $clog2(NUM_BYTES);
    localparam int unsigned TOT_W = BYTE_W * NUM_BYTES;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TOT_W-1:0]   opa_q, opa_d;
    logic [TOT_W-1:0]   opb_q, opb_d;
    logic               carry_q, carry_d;
    logic [TOT_W-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;

    logic [BYTE_W-1:0]  add_a, add_b, add_sum;
    logic               add_ovf;
    logic               last_byte;

    assign add_a     = opa_q[idx_q*BYTE_W +: BYTE_W];
    assign add_b     = opb_q[idx_q*BYTE_W +: BYTE_W];
    assign last_byte = (idx_q == IDX_W'(NUM_BYTES - 1));

    adder_8bit u_adder (
        .a        (add_a),
        .b        (add_b),
        .carry_in (carry_q),
        .sum      (add_sum),
        .overflow (add_ovf)
    );

    // Next-state, counter and datapath register updates.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    opa_d   = in_a;
                    opb_d   = in_b;
                    carry_d = in_carry;
                    idx_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                sum_d[idx_q*BYTE_W +: BYTE_W] = add_sum;
                carry_d = add_ovf;
                idx_d   = idx_q + 1'b1;
                if (last_byte) begin
                    cout_d  = add_ovf;
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == ADD);
    assign out_valid = (state_q == DONE);
    assign out_sum   = sum_q;
    assign out_carry = cout_q;

endmodule
